// File: rtl/flash_pkg.sv
// ============================================================================
// Module  : flash_pkg
// Brief   : Shared constants, FSM state encoding and helpers for the
//           bus-to-SPI-flash read bridge.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package flash_pkg;

    // spi_tx command bytes
    localparam logic [7:0] CMD_READ = 8'h03;
    localparam logic [7:0] CMD_WAKE = 8'hAB;

    // Bridge FSM states
    typedef enum logic [2:0] {
        ST_WAKE_CMD   = 3'd0,
        ST_WAKE_WAIT  = 3'd1,
        ST_WAKE_DELAY = 3'd2,
        ST_IDLE       = 3'd3,
        ST_ISSUE      = 3'd4,
        ST_SETTLE     = 3'd5,
        ST_WAIT       = 3'd6,
        ST_ACK        = 3'd7
    } state_t;

    // Flash returns the lowest-addressed byte in [31:24]; the bus is little-endian.
    function automatic logic [31:0] bswap32(input logic [31:0] w);
        return {w[7:0], w[15:8], w[23:16], w[31:24]};
    endfunction

endpackage

`default_nettype wire

// File: rtl/flash_read.sv
// ============================================================================
// Module  : flash_read
// Brief   : Turns 32-bit bus word reads into spi_tx 0x03 read transactions,
//           wakes the flash (0xAB) after reset and keeps a one-word cache.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module flash_read
    import flash_pkg::*;
#(
    parameter logic [23:0] FLASH_OFFSET = 24'h100000,
    parameter logic [15:0] WAKE_CYCLES  = 16'd100
) (
    input  logic        ck,
    input  logic        rst,
    input  logic        bus_cyc,
    input  logic [31:0] bus_adr,
    output logic [31:0] bus_rdt,
    output logic        bus_ack,
    output logic [7:0]  code,
    output logic [23:0] addr,
    output logic        tx_addr,
    output logic        no_read,
    output logic        req,
    input  logic [31:0] rdata,
    input  logic        ready
);

    state_t      state_q, state_d;
    logic        req_q, req_d;
    logic [7:0]  code_q, code_d;
    logic [23:0] addr_q, addr_d;
    logic        tx_addr_q, tx_addr_d;
    logic        no_read_q, no_read_d;
    logic        ack_q, ack_d;
    logic [31:0] rdt_q, rdt_d;
    logic        valid_q, valid_d;
    logic [21:0] tag_q, tag_d;
    logic [31:0] data_q, data_d;
    logic [21:0] idx_q, idx_d;
    logic [15:0] cnt_q, cnt_d;

    logic        hit;
    logic        delay_done;
    logic        unused_adr_bits;

    assign hit        = valid_q && (tag_q == bus_adr[23:2]);
    // Widened compare so WAKE_CYCLES of zero still terminates after one cycle.
    assign delay_done = ({1'b0, cnt_q} + 17'd1) >= {1'b0, WAKE_CYCLES};
    assign unused_adr_bits = ^{bus_adr[31:24], bus_adr[1:0]};

    assign req     = req_q;
    assign code    = code_q;
    assign addr    = addr_q;
    assign tx_addr = tx_addr_q;
    assign no_read = no_read_q;
    assign bus_ack = ack_q;
    assign bus_rdt = rdt_q;

    // State register
    always_ff @(posedge ck) begin
        if (rst) state_q <= ST_WAKE_CMD;
        else     state_q <= state_d;
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_WAKE_CMD:   state_d = ST_SETTLE;
            ST_WAKE_WAIT:  if (ready) state_d = ST_WAKE_DELAY;
            ST_WAKE_DELAY: if (delay_done) state_d = ST_IDLE;
            ST_IDLE:       if (bus_cyc) state_d = hit ? ST_ACK : ST_ISSUE;
            ST_ISSUE:      state_d = ST_SETTLE;
            // The command just issued tells us whether this was the wake-up.
            ST_SETTLE:     state_d = (code_q == CMD_READ) ? ST_WAIT : ST_WAKE_WAIT;
            ST_WAIT:       if (ready) state_d = ST_ACK;
            ST_ACK:        state_d = ST_IDLE;
            default:       state_d = ST_WAKE_CMD;
        endcase
    end

    // Output / datapath next values; spi_tx fields are registered on entry to
    // ISSUE so that req and its command are visible during the ISSUE cycle.
    always_comb begin
        req_d     = 1'b0;
        code_d    = code_q;
        addr_d    = addr_q;
        tx_addr_d = tx_addr_q;
        no_read_d = no_read_q;
        ack_d     = 1'b0;
        rdt_d     = rdt_q;
        valid_d   = valid_q;
        tag_d     = tag_q;
        data_d    = data_q;
        idx_d     = idx_q;
        cnt_d     = 16'd0;
        case (state_q)
            ST_WAKE_CMD: begin
                req_d     = 1'b1;
                code_d    = CMD_WAKE;
                tx_addr_d = 1'b0;
                no_read_d = 1'b1;
            end
            ST_WAKE_DELAY: cnt_d = cnt_q + 16'd1;
            ST_IDLE: begin
                if (bus_cyc) begin
                    if (hit) begin
                        rdt_d = data_q;
                        ack_d = 1'b1;
                    end else begin
                        idx_d     = bus_adr[23:2];
                        req_d     = 1'b1;
                        code_d    = CMD_READ;
                        addr_d    = FLASH_OFFSET + {bus_adr[23:2], 2'b00};
                        tx_addr_d = 1'b1;
                        no_read_d = 1'b0;
                    end
                end
            end
            ST_WAIT: begin
                if (ready) begin
                    rdt_d   = bswap32(rdata);
                    data_d  = bswap32(rdata);
                    tag_d   = idx_q;
                    valid_d = 1'b1;
                    // Requester may have withdrawn; cache still fills.
                    ack_d   = bus_cyc;
                end
            end
            default: ;
        endcase
    end

    // Datapath registers
    always_ff @(posedge ck) begin
        if (rst) begin
            req_q     <= 1'b0;
            code_q    <= 8'h00;
            addr_q    <= 24'h000000;
            tx_addr_q <= 1'b0;
            no_read_q <= 1'b1;
            ack_q     <= 1'b0;
            rdt_q     <= 32'h0;
            valid_q   <= 1'b0;
            tag_q     <= 22'h0;
            data_q    <= 32'h0;
            idx_q     <= 22'h0;
            cnt_q     <= 16'd0;
        end else begin
            req_q     <= req_d;
            code_q    <= code_d;
            addr_q    <= addr_d;
            tx_addr_q <= tx_addr_d;
            no_read_q <= no_read_d;
            ack_q     <= ack_d;
            rdt_q     <= rdt_d;
            valid_q   <= valid_d;
            tag_q     <= tag_d;
            data_q    <= data_d;
            idx_q     <= idx_d;
            cnt_q     <= cnt_d;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_flash_read.sv
// ============================================================================
// Module  : tb_flash_read
// Brief   : Scoreboard bench for flash_read with a behavioural spi_tx and a
//           0x03/0xAB flash model.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_flash_read;
    import flash_pkg::*;

    logic        ck;
    logic        rst;
    logic        bus_cyc;
    logic [31:0] bus_adr;
    logic [31:0] bus_rdt;
    logic        bus_ack;
    logic [7:0]  code;
    logic [23:0] addr;
    logic        tx_addr;
    logic        no_read;
    logic        req;
    logic [31:0] rdata;
    logic        ready;

    typedef struct {
        logic [7:0]  code;
        logic [23:0] addr;
        logic        tx;
        logic        nr;
    } req_t;

    req_t        exp_req[$];
    logic [31:0] exp_rdt[$];
    int          checks    = 0;
    int          failures  = 0;
    int          ack_count = 0;
    int          req_seen  = 0;

    flash_read #(.FLASH_OFFSET(24'h100000), .WAKE_CYCLES(16'd100)) dut (
        .ck(ck), .rst(rst), .bus_cyc(bus_cyc), .bus_adr(bus_adr),
        .bus_rdt(bus_rdt), .bus_ack(bus_ack), .code(code), .addr(addr),
        .tx_addr(tx_addr), .no_read(no_read), .req(req), .rdata(rdata),
        .ready(ready)
    );

    initial ck = 1'b0;
    always #5 ck = ~ck;

    // Flash contents: 11 22 33 44 at 0x100004, elsewhere low byte ^ 0xA5
    function automatic logic [7:0] flash_byte(input logic [23:0] a);
        case (a)
            24'h100004: return 8'h11;
            24'h100005: return 8'h22;
            24'h100006: return 8'h33;
            24'h100007: return 8'h44;
            default:    return a[7:0] ^ 8'hA5;
        endcase
    endfunction

    // Behavioural spi_tx: ready drops the cycle after req, 64 bits at ck/2 for a read
    logic [7:0]  busy_cnt;
    logic [23:0] cap_addr;
    logic        cap_read;
    always @(posedge ck) begin
        if (rst) begin
            ready    <= 1'b1;
            busy_cnt <= 8'd0;
            rdata    <= 32'h0;
            cap_addr <= 24'h0;
            cap_read <= 1'b0;
        end else if (busy_cnt != 8'd0) begin
            busy_cnt <= busy_cnt - 8'd1;
            if (busy_cnt == 8'd1) begin
                ready <= 1'b1;
                if (cap_read)
                    rdata <= {flash_byte(cap_addr), flash_byte(cap_addr + 24'd1),
                              flash_byte(cap_addr + 24'd2), flash_byte(cap_addr + 24'd3)};
            end
        end else if (req) begin
            ready    <= 1'b0;
            cap_read <= (code == CMD_READ);
            cap_addr <= addr;
            busy_cnt <= (code == CMD_READ) ? 8'd128 : 8'd16;
        end
    end

    // Monitor: pops expected spi_tx commands and bus words as the DUT presents them
    initial begin
        logic prev_req;
        req_t e;
        logic [31:0] d;
        prev_req = 1'b0;
        forever begin
            @(negedge ck);
            if (rst) begin
                prev_req = 1'b0;
            end else begin
                if (req) begin
                    req_seen++;
                    checks++;
                    if (!ready || prev_req) begin
                        failures++;
                        $display("FAIL req_protocol: ready=%0b prev_req=%0b required ready=1 prev_req=0", ready, prev_req);
                    end
                    checks++;
                    if (exp_req.size() == 0) begin
                        failures++;
                        $display("FAIL unexpected_req: code=%h addr=%h, required no req", code, addr);
                    end else begin
                        e = exp_req.pop_front();
                        if (code !== e.code || addr !== e.addr || tx_addr !== e.tx || no_read !== e.nr) begin
                            failures++;
                            $display("FAIL req_fields: got code=%h addr=%h tx=%0b nr=%0b, required code=%h addr=%h tx=%0b nr=%0b",
                                     code, addr, tx_addr, no_read, e.code, e.addr, e.tx, e.nr);
                        end
                    end
                end
                prev_req = req;
                if (bus_ack) begin
                    ack_count++;
                    checks++;
                    if (exp_rdt.size() == 0) begin
                        failures++;
                        $display("FAIL unexpected_ack: rdt=%h, required no ack", bus_rdt);
                    end else begin
                        d = exp_rdt.pop_front();
                        if (bus_rdt !== d) begin
                            failures++;
                            $display("FAIL ack_data: got %h, required %h", bus_rdt, d);
                        end
                    end
                end
            end
        end
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            failures++;
            $display("FAIL %s: got %h, required %h", name, got, want);
        end
    endtask

    // One bus read; cycle 0 is the first cycle the DUT sees bus_cyc in IDLE
    task automatic do_read(input logic [31:0] adr, input logic [31:0] want,
                           input bit miss, input logic [23:0] want_addr);
        int lat;
        int want_lat;
        want_lat = miss ? 131 : 1;
        lat = -1;
        if (miss) exp_req.push_back('{CMD_READ, want_addr, 1'b1, 1'b0});
        exp_rdt.push_back(want);
        @(posedge ck); #1;
        bus_adr = adr;
        bus_cyc = 1'b1;
        for (int i = 1; i <= 400; i++) begin
            @(posedge ck); #1;
            if (bus_ack) begin
                lat = i;
                break;
            end
        end
        bus_cyc = 1'b0;
        check($sformatf("latency_%h", adr), lat, want_lat);
        @(posedge ck); #1;
        check($sformatf("rdt_hold_%h", adr), bus_rdt, want);
    endtask

    initial begin
        int acks_before;
        rst     = 1'b1;
        bus_cyc = 1'b0;
        bus_adr = 32'h0;
        repeat (3) @(posedge ck);
        #1;
        check("rst_req", {31'h0, req}, 32'h0);
        check("rst_ack", {31'h0, bus_ack}, 32'h0);
        check("rst_rdt", bus_rdt, 32'h0);
        check("rst_code", {24'h0, code}, 32'h0);
        check("rst_addr", {8'h0, addr}, 32'h0);
        check("rst_tx_addr", {31'h0, tx_addr}, 32'h0);
        check("rst_no_read", {31'h0, no_read}, 32'h1);

        // Wake-up: exactly one AB, bus requests ignored during the delay
        exp_req.push_back('{CMD_WAKE, 24'h0, 1'b0, 1'b1});
        rst = 1'b0;
        repeat (30) @(posedge ck);
        #1;
        bus_adr = 32'h4;
        bus_cyc = 1'b1;
        repeat (70) @(posedge ck);
        #1;
        bus_cyc = 1'b0;
        check("wake_no_ack", ack_count, 0);
        repeat (100) @(posedge ck);
        check("wake_req_count", req_seen, 1);

        do_read(32'h0000_0004, 32'h44332211, 1'b1, 24'h100004);
        do_read(32'h0000_0004, 32'h44332211, 1'b0, 24'h0);
        do_read(32'h0000_0006, 32'h44332211, 1'b0, 24'h0);
        do_read(32'h0000_0008, 32'hAEAFACAD, 1'b1, 24'h100008);
        do_read(32'h0000_0004, 32'h44332211, 1'b1, 24'h100004);
        do_read(32'h00FF_FFFC, 32'h5A5B5859, 1'b1, 24'h0FFFFC);
        check("req_total", req_seen, 5);

        // Reset in the middle of a miss: no ack, fresh wake, cache invalid
        acks_before = ack_count;
        exp_req.push_back('{CMD_READ, 24'h100004, 1'b1, 1'b0});
        @(posedge ck); #1;
        bus_adr = 32'h4;
        bus_cyc = 1'b1;
        repeat (50) @(posedge ck);
        #1;
        rst = 1'b1;
        bus_cyc = 1'b0;
        repeat (3) @(posedge ck);
        #1;
        exp_req.push_back('{CMD_WAKE, 24'h0, 1'b0, 1'b1});
        rst = 1'b0;
        repeat (200) @(posedge ck);
        check("abort_no_ack", ack_count, acks_before);
        check("abort_req_total", req_seen, 7);
        do_read(32'h00FF_FFFC, 32'h5A5B5859, 1'b1, 24'h0FFFFC);

        repeat (5) @(posedge ck);
        check("exp_req_drained", exp_req.size(), 0);
        check("exp_rdt_drained", exp_rdt.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

`default_nettype wire
